// File: rtl/instr_encoder.sv
// Field-level instruction encoder. Packs one request's fields into the 16-bit
// CPU encoding and writes it, plus an optional extension word, into instruction RAM.
// Optional running checksum of written words: define INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_format,
  input  logic [6:0]        in_opcode,
  input  logic [3:0]        in_cond,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [2:0]        in_rc,
  input  logic [15:0]       in_imm,
  input  logic              in_ext,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       checksum
);

  localparam logic [ADDR_W-1:0] MaxAddr   = '1;
  localparam logic [ADDR_W-1:0] ResetAddr = ADDR_W'(RESET_ADDR);

  typedef enum logic [1:0] {StIdle, StEmit1, StEmit2} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       imm_q, imm_d;
  logic              ext_q, ext_d;

  logic        accept;
  logic        bad_cond, bad_fmt, no_room, reject;
  logic [1:0]  rej_code;
  logic [15:0] packed_word;

  assign in_ready = (state_q == StIdle) & ~full_q & ~addr_load;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != StIdle);
  assign full     = full_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign ram_wren = wren_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;

  // Request screening; direct (4) and illegal (7) carry no condition field
  always_comb begin
    bad_cond = (in_format != 3'd4) && (in_format != 3'd7) && (in_cond == 4'b1110);
    bad_fmt  = (in_format == 3'd7) || ((in_format == 3'd4) && (in_opcode[1:0] == 2'b11));
    no_room  = in_ext && (ptr_q == MaxAddr);
    reject   = bad_cond | bad_fmt | no_room;
    if (bad_cond)     rej_code = 2'd0;
    else if (bad_fmt) rej_code = 2'd1;
    else              rej_code = 2'd2;
  end

  // Field packing for the first instruction word
  always_comb begin
    packed_word = 16'h0000;
    case (in_format)
      3'd0:    packed_word = {3'b000, in_opcode[5:0], in_cond, in_ra};
      3'd1:    packed_word = {3'b001, in_opcode[1:0], in_cond, in_ra, in_imm[3:0]};
      3'd2:    packed_word = {2'b01, in_opcode[3:0], in_cond, in_ra, in_rb};
      3'd3:    packed_word = {2'b10, in_opcode[0], in_cond, in_rc, in_rb, in_ra};
      3'd4:    packed_word = {2'b11, in_opcode[1:0], in_imm[11:0]};
      3'd5:    packed_word = {5'b11110, in_opcode[6:0], in_cond};
      3'd6:    packed_word = {5'b11111, in_opcode[3:0], in_cond, in_imm[2:0]};
      default: packed_word = 16'h0000;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= ResetAddr;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      wren_q     <= 1'b0;
      addr_q     <= ResetAddr;
      data_q     <= 16'h0000;
      imm_q      <= 16'h0000;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      full_q     <= full_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      imm_q      <= imm_d;
      ext_q      <= ext_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !reject) state_d = StEmit1;
      StEmit1: state_d = ext_q ? StEmit2 : StIdle;
      StEmit2: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath next values; a write is in flight during every Emit state
  always_comb begin
    ptr_d      = ptr_q;
    full_d     = full_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    imm_d      = imm_q;
    ext_d      = ext_q;
    unique case (state_q)
      StIdle: begin
        if (addr_load) begin
          ptr_d      = addr_in;
          full_d     = 1'b0;
          err_code_d = 2'd0;
        end else if (accept) begin
          if (reject) begin
            err_d      = 1'b1;
            err_code_d = rej_code;
          end else begin
            wren_d = 1'b1;
            addr_d = ptr_q;
            data_d = packed_word;
            imm_d  = in_imm;
            ext_d  = in_ext;
          end
        end
      end
      StEmit1, StEmit2: begin
        // Pointer saturates at the top address instead of wrapping
        if (ptr_q == MaxAddr) full_d = 1'b1;
        else                  ptr_d  = ptr_q + 1'b1;
        if (state_q == StEmit1 && ext_q) begin
          wren_d = 1'b1;
          addr_d = ptr_q + 1'b1;
          data_d = imm_q;
        end
      end
      default: ;
    endcase
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0] csum_q;

  // Running sum of every word written; cleared by an honoured addr_load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 16'h0000;
    end else if (state_q == StIdle && addr_load) begin
      csum_q <= 16'h0000;
    end else if (wren_q) begin
      csum_q <= csum_q + data_q;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases with literal expectations
// followed by randomized traffic checked every cycle against a queue-based model.
module tb_instr_encoder;

  localparam int unsigned AW   = 8;
  localparam logic [AW-1:0] MAXA = '1;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  localparam logic [15:0] SIM_SUM = 16'h1866;
`else
  localparam logic [15:0] SIM_SUM = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [2:0]    in_format;
  logic [6:0]    in_opcode;
  logic [3:0]    in_cond;
  logic [2:0]    in_ra, in_rb, in_rc;
  logic [15:0]   in_imm;
  logic          in_ext;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic          ram_wren, busy, full, err;
  logic [1:0]    err_code;
  logic [15:0]   checksum;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .RESET_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_format(in_format), .in_opcode(in_opcode), .in_cond(in_cond),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm), .in_ext(in_ext),
    .addr_load(addr_load), .addr_in(addr_in), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .busy(busy), .full(full), .err(err), .err_code(err_code),
    .checksum(checksum)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Encoding rules written directly from the field tables
  function automatic logic [15:0] pack(input logic [2:0] f, input logic [6:0] op,
                                       input logic [3:0] c, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [2:0] rc,
                                       input logic [15:0] imm);
    case (f)
      3'd0:    return {3'b000, op[5:0], c, ra};
      3'd1:    return {3'b001, op[1:0], c, ra, imm[3:0]};
      3'd2:    return {2'b01, op[3:0], c, ra, rb};
      3'd3:    return {2'b10, op[0], c, rc, rb, ra};
      3'd4:    return {2'b11, op[1:0], imm[11:0]};
      3'd5:    return {5'b11110, op[6:0], c};
      3'd6:    return {5'b11111, op[3:0], c, imm[2:0]};
      default: return 16'h0000;
    endcase
  endfunction

  // Transaction model: queue of pending RAM writes, head is the write on the bus
  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t           mq[$];
  wr_t           w;
  logic [AW-1:0] m_ptr;
  logic          m_full, m_err;
  logic [1:0]    m_code;
  logic [15:0]   m_sum;
  bit            m_idle, c_idle;
  bit            chk_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ptr  = '0;
      m_full = 1'b0;
      m_err  = 1'b0;
      m_code = 2'd0;
      m_sum  = 16'h0000;
    end else begin
      m_idle = (mq.size() == 0);
      m_err  = 1'b0;
      if (m_idle) begin
        if (addr_load) begin
          m_ptr  = addr_in;
          m_full = 1'b0;
          m_code = 2'd0;
          m_sum  = 16'h0000;
        end else if (in_valid && !m_full) begin
          if (in_format != 3'd4 && in_format != 3'd7 && in_cond == 4'he) begin
            m_err = 1'b1; m_code = 2'd0;
          end else if (in_format == 3'd7 || (in_format == 3'd4 && in_opcode[1:0] == 2'b11)) begin
            m_err = 1'b1; m_code = 2'd1;
          end else if (in_ext && m_ptr == MAXA) begin
            m_err = 1'b1; m_code = 2'd2;
          end else begin
            mq.push_back('{m_ptr, pack(in_format, in_opcode, in_cond, in_ra, in_rb, in_rc,
                                       in_imm)});
            if (in_ext) mq.push_back('{m_ptr + 1'b1, in_imm});
          end
        end
      end else begin
        w = mq.pop_front();
`ifdef INSTR_ENCODER_CHECKSUM_EN
        m_sum = m_sum + w.d;
`endif
        if (w.a == MAXA) m_full = 1'b1;
        else             m_ptr  = w.a + 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      c_idle = (mq.size() == 0);
      check("in_ready", 32'(in_ready), 32'(c_idle && !m_full && !addr_load));
      check("busy", 32'(busy), 32'(!c_idle));
      check("ram_wren", 32'(ram_wren), 32'(!c_idle));
      if (!c_idle) begin
        check("ram_addr", 32'(ram_addr), 32'(mq[0].a));
        check("ram_data", 32'(ram_data), 32'(mq[0].d));
      end
      check("full", 32'(full), 32'(m_full));
      check("err", 32'(err), 32'(m_err));
      check("err_code", 32'(err_code), 32'(m_code));
      check("checksum", 32'(checksum), 32'(m_sum));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a);
    addr_load = 1'b1;
    addr_in   = a;
    tick();
    addr_load = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [3:0] c,
                            input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc,
                            input logic [15:0] imm, input logic ext);
    in_format = f; in_opcode = op; in_cond = c;
    in_ra = ra; in_rb = rb; in_rc = rc; in_imm = imm; in_ext = ext;
  endtask

  // One-cycle request, returns one time unit after the accepting edge
  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [3:0] c,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc,
                     input logic [15:0] imm, input logic ext);
    set_fields(f, op, c, ra, rb, rc, imm, ext);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_in = '0;
    set_fields(3'd0, 7'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    repeat (3) tick();
    rst_n  = 1'b1;
    chk_en = 1;

    // Reset state
    @(negedge clk);
    check("rst ram_wren", 32'(ram_wren), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst ram_data", 32'(ram_data), 32'd0);
    check("rst checksum", 32'(checksum), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    tick();

    // Double ADD at 0x10, then direct and control words at the following addresses
    load(8'h10);
    req(3'd2, 7'h00, 4'b0110, 3'd3, 3'd5, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("add wren", 32'(ram_wren), 32'd1);
    check("add addr", 32'(ram_addr), 32'h10);
    check("add data", 32'(ram_data), 32'h419D);
    tick();
    @(negedge clk);
    check("add wren done", 32'(ram_wren), 32'd0);
    tick();
    req(3'd4, 7'h00, 4'b0000, 3'd0, 3'd0, 3'd0, 16'h0ABC, 1'b0);
    @(negedge clk);
    check("jmd addr", 32'(ram_addr), 32'h11);
    check("jmd data", 32'(ram_data), 32'hCABC);
    tick(); tick();
    req(3'd5, 7'h01, 4'b0110, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("stp addr", 32'(ram_addr), 32'h12);
    check("stp data", 32'(ram_data), 32'hF016);
    tick(); tick();

    // SIM with extension word
    load(8'h20);
    req(3'd0, 7'h0C, 4'b0110, 3'd2, 3'd0, 3'd0, 16'h1234, 1'b1);
    @(negedge clk);
    check("sim w1 addr", 32'(ram_addr), 32'h20);
    check("sim w1 data", 32'(ram_data), 32'h0632);
    check("sim w1 ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("sim w2 wren", 32'(ram_wren), 32'd1);
    check("sim w2 addr", 32'(ram_addr), 32'h21);
    check("sim w2 data", 32'(ram_data), 32'h1234);
    check("sim w2 ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("sim done wren", 32'(ram_wren), 32'd0);
    check("sim checksum", 32'(checksum), 32'(SIM_SUM));
    tick();

    // Rejections
    req(3'd2, 7'h00, 4'b1110, 3'd1, 3'd1, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("badcond err", 32'(err), 32'd1);
    check("badcond code", 32'(err_code), 32'd0);
    check("badcond wren", 32'(ram_wren), 32'd0);
    tick();
    @(negedge clk);
    check("err pulse end", 32'(err), 32'd0);
    tick();
    req(3'd7, 7'h00, 4'b0000, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("badfmt code", 32'(err_code), 32'd1);
    tick();
    req(3'd4, 7'h03, 4'b0000, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("direct op3 code", 32'(err_code), 32'd1);
    tick();
    load(MAXA);
    req(3'd2, 7'h00, 4'b0110, 3'd1, 3'd1, 3'd0, 16'h5555, 1'b1);
    @(negedge clk);
    check("noroom err", 32'(err), 32'd1);
    check("noroom code", 32'(err_code), 32'd2);
    tick();

    // Fill the last address, then reload while a request is offered
    req(3'd2, 7'h00, 4'b0110, 3'd3, 3'd5, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("last addr", 32'(ram_addr), 32'(MAXA));
    tick();
    @(negedge clk);
    check("full set", 32'(full), 32'd1);
    check("full ready", 32'(in_ready), 32'd0);
    tick();
    set_fields(3'd5, 7'h01, 4'b0110, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    in_valid = 1'b1; addr_load = 1'b1; addr_in = 8'h03;
    tick();
    in_valid = 1'b0; addr_load = 1'b0;
    @(negedge clk);
    check("reload full", 32'(full), 32'd0);
    check("reload not taken", 32'(busy), 32'd0);
    tick();
    req(3'd5, 7'h01, 4'b0110, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("reload addr", 32'(ram_addr), 32'h03);
    tick(); tick();

    // Reset during the first word of an extended instruction
    req(3'd0, 7'h0C, 4'b0110, 3'd2, 3'd0, 3'd0, 16'hBEEF, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst wren", 32'(ram_wren), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst addr", 32'(ram_addr), 32'd0);
    check("midrst data", 32'(ram_data), 32'd0);
    tick();
    @(negedge clk);
    check("midrst no w2", 32'(ram_wren), 32'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 249) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      addr_load = ($urandom_range(0, 19) == 0);
      addr_in   = ($urandom_range(0, 3) == 0) ? MAXA - AW'($urandom_range(0, 2)) : AW'($urandom);
      set_fields(3'($urandom), 7'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'he : 4'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0));
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; addr_load = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Field-level instruction encoder, the inverse of the CPU decoder.
- Accepts one instruction per handshake as format, opcode, condition, register and immediate fields, and packs it into the 16-bit CPU encoding.
- Writes the resulting word(s) sequentially into instruction RAM.
- Used by the program loader/debug path to build programs in hardware. Two-word instructions (LDI/AIM/SIM immediates) are emitted as two consecutive RAM writes.

Parameters:
- ADDR_W, 8, instruction RAM address width.
- RESET_ADDR, 0, write address after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_format  in  3  0 single, 1 single_ba, 2 double, 3 triple, 4 direct, 5 control, 6 control_offset, 7 illegal
- in_opcode  in  7  opcode field, LSBs used per format
- in_cond  in  4  condition code
- in_ra  in  3  reg A: Rd / write reg / single reg
- in_rb  in  3  reg B: Rs / read2
- in_rc  in  3  reg C: triple write reg
- in_imm  in  16  bit index / address / offset / extension word
- in_ext  in  1  emit in_imm as a second word
- addr_load  in  1  load write pointer
- addr_in  in  ADDR_W  new write pointer
- ram_addr  out  ADDR_W  instruction RAM write address
- ram_data  out  16  instruction RAM write data
- ram_wren  out  1  instruction RAM write enable
- busy  out  1  state != IDLE
- full  out  1  last address written
- err  out  1  one-cycle reject pulse
- err_code  out  2  0 bad cond, 1 bad format/opcode, 2 no room
- checksum  out  16  see Optional Feature

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE, write pointer RESET_ADDR.
  - ram_wren, busy, full, err all 0; err_code 0; ram_addr RESET_ADDR; ram_data 0; checksum 0.
  - Reset mid-emission abandons the second word; no further write occurs.
- Handshake:
  - in_ready = (state==IDLE) & ~full & ~addr_load.
  - A transfer happens when in_valid & in_ready are high on a clk edge. Fields are registered on accept.
- Packing (concatenations, MSB first):
  - single: {000, op[5:0], cond, ra}
  - single_ba: {001, op[1:0], cond, ra, imm[3:0]}
  - double: {01, op[3:0], cond, ra, rb}
  - triple: {10, op[0], cond, rc, rb, ra}
  - direct: {11, op[1:0], imm[11:0]}; op=11 is illegal; cond ignored.
  - control: {11110, op[6:0], cond}
  - control_offset: {11111, op[3:0], cond, imm[2:0]}
- Rejection:
  - A request is rejected if cond==1110 in a cond-bearing format (code 0), format 7 or direct op 11 (code 1), or in_ext with pointer == 2^ADDR_W-1 (code 2).
  - On rejection: err=1 for the cycle after accept, err_code holds until the next err, no RAM write, pointer unchanged, state stays IDLE.
- FSM:
  - IDLE -> EMIT1 on a valid accept.
  - EMIT1: ram_wren=1 with the packed word at the pointer; pointer+1. Goes to EMIT2 if ext, else IDLE.
  - EMIT2: ram_wren=1 with imm at the pointer; pointer+1; -> IDLE.
  - Latency: first write 1 cycle after accept, extension word 2 cycles after. Throughput is one instruction per 2 cycles (3 if ext).
  - ram_addr/ram_data are registered and valid only while ram_wren=1.
- Full:
  - A write to address 2^ADDR_W-1 sets full; the pointer does not wrap.
  - full holds in_ready low until addr_load.
- addr_load:
  - Honoured only in IDLE; ignored while busy.
  - Sets pointer=addr_in, clears full and err_code.
  - Has priority over an in_valid in the same cycle; that request is not accepted.

Optional Feature:
- Macro INSTR_ENCODER_CHECKSUM_EN.
- Defined: checksum is the 16-bit modulo-2^16 sum of every word written (both words of ext instructions). It updates the cycle after each write and is cleared by reset and by an honoured addr_load.
- Undefined: checksum is tied to 16'h0000 and no adder is built.

Test Plan:
- Double ADD: format 2, op 0000, cond 0110, ra 3, rb 5 at pointer 0x10 -> ram_wren 1 cycle after accept, addr 0x10, data 0x419D; pointer becomes 0x11.
- SIM with ext: format 0, op 001100, cond 0110, ra 2, imm 0x1234, ext=1 -> writes 0x0632 then 0x1234 on consecutive cycles; in_ready low for 2 cycles; checksum (with EN) 0x1866.
- Direct JMD / control STP: format 4, op 00, imm 0x0ABC -> 0xCABC. Format 5, op 0000001, cond 0110 -> 0xF016.
- Rejects: cond 1110 on format 2 -> err pulse, err_code 0, no write. Format 7 -> err_code 1. ADDR_W=4, pointer 0xF with ext -> err_code 2.
- Full/reload: ADDR_W=4, write at 0xF -> full=1, in_ready=0. addr_load 0x3 together with in_valid -> request not accepted, full=0, next accept writes addr 0x3.
- Reset mid-op: assert rst_n=0 during EMIT1 of an ext instruction -> no EMIT2 write, all outputs at reset values next cycle.
